// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS-to-RAVENS event path.
package dvs_ravens_pkg;

   localparam int unsigned TIMESTAMP_US_BITS      = 32;

   localparam int unsigned STAMP_ARB_NUM_REQ      = 4;
   localparam int unsigned STAMP_ARB_PAYLOAD_BITS = 16;
   localparam int unsigned STAMP_ARB_SRC_BITS     = $clog2(STAMP_ARB_NUM_REQ);

   // Occupancy of the single-entry output stage of the stamp arbiter.
   typedef enum logic {
      STAGE_EMPTY = 1'b0,
      STAGE_FULL  = 1'b1
   } stage_state_t;

   // One stamped entry as seen downstream (default-sized arbiter).
   typedef struct packed {
      logic                              wrap;
      logic [STAMP_ARB_SRC_BITS-1:0]     src;
      logic [STAMP_ARB_PAYLOAD_BITS-1:0] payload;
      logic [TIMESTAMP_US_BITS-1:0]      time_us;
   } stamped_event_t;

endpackage

// File: rtl/event_stamp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after 'last'.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [31:0] cand;

   // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = (32'(last) + 32'(k)) % 32'(NUM_REQ);
         if (en && !grant_any && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
            grant_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/event_stamp_arbiter.sv
// Stamps events from several requesters with time_us under round-robin
// arbitration and inserts a wrap marker whenever the timer rolls over.
module event_stamp_arbiter
   import dvs_ravens_pkg::*;
#(
   parameter  int unsigned NUM_REQ      = STAMP_ARB_NUM_REQ,
   parameter  int unsigned PAYLOAD_BITS = STAMP_ARB_PAYLOAD_BITS,
   localparam int unsigned SRC_BITS     = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [TIMESTAMP_US_BITS-1:0]      time_us,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0]   req_payload,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_wrap,
   output logic [SRC_BITS-1:0]               out_src,
   output logic [PAYLOAD_BITS-1:0]           out_payload,
   output logic [TIMESTAMP_US_BITS-1:0]      out_time_us
);

   stage_state_t                   state;
   logic [TIMESTAMP_US_BITS-1:0]   prev_time_us;
   logic                           wrap_pending;
   logic [SRC_BITS-1:0]            last;

   logic                           load;
   logic                           wrap_evt;
   logic                           marker_req;
   logic                           arb_en;
   logic [NUM_REQ-1:0]             grant;
   logic [SRC_BITS-1:0]            grant_idx;
   logic                           grant_any;
   logic [PAYLOAD_BITS-1:0]        grant_payload;

   assign out_valid     = (state == STAGE_FULL);
   assign load          = (state == STAGE_EMPTY) || out_ready;
   assign wrap_evt      = (time_us < prev_time_us);
   assign marker_req    = wrap_evt || wrap_pending;
   // Markers take priority over events, and nothing is granted during reset.
   assign arb_en        = load && !marker_req && !rst;
   assign req_ready     = grant;
   assign grant_payload = req_payload[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req       (req_valid),
      .last      (last),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Output stage, wrap tracking and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= STAGE_EMPTY;
         out_wrap     <= 1'b0;
         out_src      <= '0;
         out_payload  <= '0;
         out_time_us  <= '0;
         wrap_pending <= 1'b0;
         prev_time_us <= '0;
         last         <= SRC_BITS'(NUM_REQ - 1);
      end else begin
         prev_time_us <= time_us;
         if (load) begin
            if (marker_req) begin
               state        <= STAGE_FULL;
               out_wrap     <= 1'b1;
               out_src      <= '0;
               out_payload  <= '0;
               out_time_us  <= time_us;
               wrap_pending <= 1'b0;
            end else if (grant_any) begin
               state        <= STAGE_FULL;
               out_wrap     <= 1'b0;
               out_src      <= grant_idx;
               out_payload  <= grant_payload;
               out_time_us  <= time_us;
               last         <= grant_idx;
            end else begin
               state        <= STAGE_EMPTY;
            end
         end else if (marker_req) begin
            // Stalled: remember the rollover; further wraps merge into it.
            wrap_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_event_stamp_arbiter.sv
// Self-checking bench for event_stamp_arbiter with a transaction-level model.
module tb_event_stamp_arbiter;
   import dvs_ravens_pkg::*;

   localparam int unsigned NR = STAMP_ARB_NUM_REQ;
   localparam int unsigned PB = STAMP_ARB_PAYLOAD_BITS;
   localparam int unsigned SB = STAMP_ARB_SRC_BITS;
   localparam int unsigned TS = TIMESTAMP_US_BITS;

   logic             clk = 1'b0;
   logic             rst;
   logic [TS-1:0]    time_us;
   logic [NR-1:0]    req_valid;
   logic [NR*PB-1:0] req_payload;
   logic [NR-1:0]    req_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out_wrap;
   logic [SB-1:0]    out_src;
   logic [PB-1:0]    out_payload;
   logic [TS-1:0]    out_time_us;

   event_stamp_arbiter #(
      .NUM_REQ      (NR),
      .PAYLOAD_BITS (PB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .time_us     (time_us),
      .req_valid   (req_valid),
      .req_payload (req_payload),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_wrap    (out_wrap),
      .out_src     (out_src),
      .out_payload (out_payload),
      .out_time_us (out_time_us)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Model: the entry the output register should hold, plus rollover memory.
   logic           m_valid;
   stamped_event_t m_ent;
   logic           m_pend;
   logic [TS-1:0]  m_prev;
   int             m_last;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] rv, input int lst);
      for (int k = 1; k <= int'(NR); k++)
         if (rv[(lst + k) % int'(NR)]) return (lst + k) % int'(NR);
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_ent   = '0;
      m_pend  = 1'b0;
      m_prev  = '0;
      m_last  = int'(NR) - 1;
   endtask

   function automatic logic [NR-1:0] model_ready();
      logic [NR-1:0] r;
      int            g;
      r = '0;
      g = rr_pick(req_valid, m_last);
      if ((!m_valid || out_ready) && !((time_us < m_prev) || m_pend) && g >= 0)
         r[g] = 1'b1;
      return r;
   endfunction

   // Advance the model by one accepted clock edge using the inputs held across it.
   task automatic model_clock();
      logic ld, mk;
      int   g;
      ld = !m_valid || out_ready;
      mk = (time_us < m_prev) || m_pend;
      g  = rr_pick(req_valid, m_last);
      if (ld) begin
         if (mk) begin
            m_valid = 1'b1;
            m_ent   = '{wrap: 1'b1, src: '0, payload: '0, time_us: time_us};
            m_pend  = 1'b0;
         end else if (g >= 0) begin
            m_valid = 1'b1;
            m_ent   = '{wrap: 1'b0, src: SB'(g), payload: req_payload[g*PB +: PB], time_us: time_us};
            m_last  = g;
         end else begin
            m_valid = 1'b0;
         end
      end else if (mk) begin
         m_pend = 1'b1;
      end
      m_prev = time_us;
   endtask

   task automatic check_outputs();
      check_eq("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         check_eq("out_wrap",    64'(out_wrap),    64'(m_ent.wrap));
         check_eq("out_src",     64'(out_src),     64'(m_ent.src));
         check_eq("out_payload", 64'(out_payload), 64'(m_ent.payload));
         check_eq("out_time_us", 64'(out_time_us), 64'(m_ent.time_us));
      end
   endtask

   // One cycle: drive inputs, check req_ready, clock, check the output stage.
   task automatic step(input logic [NR-1:0] rv, input logic rdy, input logic [TS-1:0] t);
      req_valid = rv;
      out_ready = rdy;
      time_us   = t;
      #1;
      check_eq("req_ready", 64'(req_ready), 64'(model_ready()));
      @(posedge clk);
      model_clock();
      #1;
      check_outputs();
   endtask

   task automatic set_payloads(input logic [PB-1:0] p0, input logic [PB-1:0] p1,
                               input logic [PB-1:0] p2, input logic [PB-1:0] p3);
      req_payload = {p3, p2, p1, p0};
   endtask

   logic [TS-1:0] t;
   int unsigned   r;

   initial begin
      rst         = 1'b1;
      time_us     = '0;
      req_valid   = '0;
      req_payload = '0;
      out_ready   = 1'b0;
      model_reset();
      #1;
      check_eq("rst_req_ready", 64'(req_ready), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid",   64'(out_valid),   64'(0));
      check_eq("rst_out_wrap",    64'(out_wrap),    64'(0));
      check_eq("rst_out_src",     64'(out_src),     64'(0));
      check_eq("rst_out_payload", 64'(out_payload), 64'(0));
      check_eq("rst_out_time",    64'(out_time_us), 64'(0));
      rst = 1'b0;

      // All requesters valid: grants rotate 0,1,2,3,0.
      set_payloads(16'h1000, 16'h1111, 16'h2222, 16'h3333);
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1, TS'(10 + i));
         check_eq("rr_src_seq", 64'(out_src), 64'(i % 4));
      end

      // Only requester 3, then 1 and 3: grant 3 then 1.
      step(4'b1000, 1'b1, 32'd20);
      check_eq("fair_src3", 64'(out_src), 64'(3));
      step(4'b1010, 1'b1, 32'd21);
      check_eq("fair_src1", 64'(out_src), 64'(1));

      // Stall with requester 2 valid: one entry held stable.
      step(4'b0000, 1'b1, 32'd99);
      set_payloads(16'h0000, 16'h0000, 16'hBEEF, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         step(4'b0100, 1'b0, 32'd100);
         check_eq("stall_src",  64'(out_src),     64'(2));
         check_eq("stall_pay",  64'(out_payload), 64'(16'hBEEF));
         check_eq("stall_time", 64'(out_time_us), 64'(100));
      end
      step(4'b0000, 1'b1, 32'd101);

      // Rollover with requester 0 streaming: marker precedes later events.
      set_payloads(16'hA0A0, 16'h0, 16'h0, 16'h0);
      step(4'b0001, 1'b1, 32'hFFFF_FFFE);
      step(4'b0001, 1'b1, 32'h0000_0001);
      check_eq("wrap_flag", 64'(out_wrap),    64'(1));
      check_eq("wrap_time", 64'(out_time_us), 64'(1));
      step(4'b0001, 1'b1, 32'h0000_0002);
      check_eq("post_wrap_evt", 64'(out_wrap), 64'(0));

      // Wraps during a stall merge into one marker emitted afterwards.
      step(4'b0001, 1'b0, 32'd200);
      step(4'b0001, 1'b0, 32'd10);
      step(4'b0001, 1'b0, 32'd11);
      step(4'b0001, 1'b0, 32'd5);
      step(4'b0001, 1'b1, 32'd13);
      check_eq("stall_wrap_flag", 64'(out_wrap),    64'(1));
      check_eq("stall_wrap_time", 64'(out_time_us), 64'(13));
      step(4'b0001, 1'b1, 32'd14);
      check_eq("stall_wrap_next", 64'(out_wrap), 64'(0));

      // Reset while full with a pending wrap drops both.
      step(4'b0001, 1'b0, 32'd300);
      step(4'b0001, 1'b0, 32'd20);
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
      check_eq("midrst_req_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(4'b0000, 1'b1, 32'd0);
      step(4'b0000, 1'b1, 32'd0);
      check_eq("no_marker_after_rst", 64'(out_valid), 64'(0));

      // Randomized traffic against the model.
      t = 32'd1000;
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 19);
         if (r == 0)
            t = $urandom_range(0, t);
         else if (r == 1)
            t = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         else if (r > 3)
            t = t + 32'($urandom_range(1, 3));
         req_payload = {$urandom, $urandom};
         step(NR'($urandom), ($urandom_range(0, 9) < 7), t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
